// File: rtl/regfile_mp.sv
// Multi-ported integer register file with a pending-write scoreboard.
// Reads are combinational, with optional same-cycle forwarding from the write ports.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   w_addr,
    input  logic [NWR*XLEN-1:0] w_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next-state for storage and scoreboard; later write ports override earlier ones.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && (w_addr[j*AW +: AW] != {AW{1'b0}})) begin
                regs_d[w_addr[j*AW +: AW]] = w_data[j*XLEN +: XLEN];
                busy_d[w_addr[j*AW +: AW]] = 1'b0;
            end else begin
                busy_d = busy_d;
            end
        end
        // Issue is applied after the write clears so that marking pending wins.
        if (iss_valid && (iss_addr != {AW{1'b0}})) begin
            busy_d[iss_addr] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        regs_d[0] = {XLEN{1'b0}};
        busy_d[0] = 1'b0;
    end

    // State register with synchronous active-low reset that also discards same-edge writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= {XLEN{1'b0}};
            end
            busy_q <= {NREGS{1'b0}};
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr_s;
        logic [XLEN-1:0] data_s;
        logic            fwd_s;

        assign addr_s = rd_addr[k*AW +: AW];

        // Read mux: stored value unless an enabled write to a nonzero address matches.
        always_comb begin
            data_s = regs_q[addr_s];
            fwd_s  = 1'b0;
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && (w_addr[j*AW +: AW] == addr_s) && (addr_s != {AW{1'b0}})) begin
                        data_s = w_data[j*XLEN +: XLEN];
                        fwd_s  = 1'b1;
                    end else begin
                        fwd_s = fwd_s;
                    end
                end
            end else begin
                fwd_s = 1'b0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data_s;
        // A forwarded read is by definition no longer waiting on its producer.
        assign rd_busy[k] = fwd_s ? 1'b0 : busy_q[addr_s];
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width in bits.
REQ-002 SHALL provide parameter NREGS, default 32, number of architectural registers (power of two, >=2).
REQ-003 SHALL provide parameter NRD, default 2, number of read ports.
REQ-004 SHALL provide parameter NWR, default 2, number of write ports.
REQ-005 SHALL provide parameter BYPASS, default 1, enables same-cycle write-to-read forwarding.
REQ-006 SHALL derive localparam AW = $clog2(NREGS).
REQ-007 SHALL provide port clk  input  1  single clock; all state updates on posedge.
REQ-008 SHALL provide port reset  input  1  reset, synchronous and active-low.
REQ-009 SHALL provide port rd_addr  input  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
REQ-010 SHALL provide port rd_data  output  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
REQ-011 SHALL provide port rd_busy  output  NRD  scoreboard busy flag of each read port's register.
REQ-012 SHALL provide port we  input  NWR  per-write-port enable.
REQ-013 SHALL provide port w_addr  input  NWR*AW  write addresses, packed as rd_addr.
REQ-014 SHALL provide port w_data  input  NWR*XLEN  write data, packed as rd_data.
REQ-015 SHALL provide port iss_valid  input  1  marks the destination register of an issuing instruction pending.
REQ-016 SHALL provide port iss_addr  input  AW  destination register being marked.
REQ-017 SHALL provide port busy_vec  output  NREGS  current scoreboard, bit r = register r pending.

Function
REQ-018 Register 0 SHALL read as 0 and never be written or marked busy; writes and issues to address 0 are ignored.
REQ-019 Write port j with we[j]=1 and w_addr!=0 SHALL update the register at the next posedge clk.
REQ-020 When several enabled write ports target the same address in one cycle, the highest-index port SHALL win; the others are dropped.
REQ-021 Reads SHALL be combinational from stored state with zero-cycle latency.
REQ-022 With BYPASS=1, a read whose address matches an enabled write port (address !=0) in the same cycle SHALL return that port's w_data, applying the REQ-020 priority; with BYPASS=0 it SHALL return the stored value.
REQ-023 Any write (we[j]=1, w_addr!=0) SHALL clear busy_vec[w_addr] at the next posedge.
REQ-024 iss_valid=1 with iss_addr!=0 SHALL set busy_vec[iss_addr] at the next posedge.
REQ-025 Issue and write to the same register in the same cycle SHALL leave that register busy (set wins over clear) while the data is still written.
REQ-026 rd_busy[k] SHALL equal busy_vec[rd_addr[k]] from stored state, except that with BYPASS=1 it SHALL read 0 when the port is forwarded per REQ-022.
REQ-027 Independent ports SHALL operate fully in parallel; any mix of NRD reads, NWR writes and one issue SHALL complete in one cycle.
REQ-028 Write and issue on the same posedge as an active reset SHALL be discarded.

Reset
REQ-029 While reset=0 at posedge clk, all NREGS registers SHALL become 0 and busy_vec SHALL become all zeros.
REQ-030 While reset is asserted, rd_data SHALL reflect reset-cleared state (0) one cycle after first assertion; forwarding remains combinational.
REQ-031 Deassertion SHALL take effect on the first posedge with reset=1; no asynchronous path from reset to state.

Verification
REQ-032 Reset: hold reset=0 two cycles, release -> every rd_data=0, busy_vec=0 for all addresses.
REQ-033 Write/read: we[0]=1, w_addr=5, w_data=0xDEADBEEF; next cycle rd_addr port0=5 -> rd_data=0xDEADBEEF; write to 0 of 0x1234 -> read 0 returns 0.
REQ-034 Conflict: we=2'b11, both w_addr=7, w_data0=0x11, w_data1=0x22 -> same-cycle forwarded read 0x22 (BYPASS=1), next cycle stored value 0x22.
REQ-035 Bypass: reg 3 holds 0xA; write 0xB to 3 while reading 3 -> rd_data=0xB with BYPASS=1, 0xA with BYPASS=0; both 0xB next cycle.
REQ-036 Scoreboard: issue 9 -> busy_vec[9]=1 next cycle, rd_busy=1 on read of 9; write 9 -> cleared next cycle; issue and write 9 same cycle -> stays 1; issue 0 -> busy_vec[0]=0.
REQ-037 Reset mid-operation: issue 4 and write 4=0x55 in the same cycle as reset=0 -> after release reg 4=0, busy_vec[4]=0.
